// File: rtl/alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer
//
// Command front-end for the 4-bit combinational ALU
// (op 00 AND, 01 shift-left, 10 OR, 11 shift-right).
//
// Commands {op, a, b} arrive over a valid/ready handshake and are queued in a
// DEPTH-entry FIFO. One command at a time is popped into an operand register
// that drives the ALU; the ALU result is captured one cycle later and held on
// a second valid/ready handshake until the consumer takes it.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   command present                      (input)
//   in_ready   command can be accepted              (output)
//   in_op      ALU opcode of the offered command    (input, 2)
//   in_a       operand a                            (input, 4)
//   in_b       operand b                            (input, 4)
//   alu_op     operand register -> ALU op port      (output, 2)
//   alu_a      operand register -> ALU a port       (output, 4)
//   alu_b      operand register -> ALU b port       (output, 4)
//   alu_d      ALU result, combinational            (input, 4)
//   out_valid  result available                     (output)
//   out_ready  downstream accepts result            (input)
//   out_op     opcode that produced out_d           (output, 2)
//   out_d      captured ALU result                  (output, 4)
//   out_zero   out_d == 0                           (output)
//   done_cnt   completed output handshakes, wraps   (output, 8)
// ---------------------------------------------------------------------------
module alu_cmd_issuer #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_op,
   input  logic [3:0] in_a,
   input  logic [3:0] in_b,
   output logic [1:0] alu_op,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   input  logic [3:0] alu_d,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_op,
   output logic [3:0] out_d,
   output logic       out_zero,
   output logic [7:0] done_cnt
);

   // Pointer carries one extra wrap bit so that full and empty are distinct.
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = 10;                     // {op[1:0], a[3:0], b[3:0]}
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Storage and state
   // ------------------------------------------------------------------------
   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] wr_ptr_d;
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] rd_ptr_d;

   state_t        state_q;
   logic [1:0]    alu_op_q;
   logic [3:0]    alu_a_q;
   logic [3:0]    alu_b_q;
   logic          out_valid_q;
   logic [1:0]    out_op_q;
   logic [3:0]    out_d_q;
   logic [7:0]    done_cnt_q;

   logic          empty_s;
   logic          full_s;
   logic          push_s;
   logic          pop_s;
   logic [EW-1:0] head_s;

   // ------------------------------------------------------------------------
   // FIFO status and handshake decode
   // ------------------------------------------------------------------------
   assign empty_s  = (wr_ptr_q == rd_ptr_q);
   assign full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // Readiness depends only on "full": a pop in the same cycle does not free
   // a slot for a push, which keeps in_ready free of any path from out_ready.
   assign in_ready = !full_s && !rst;
   assign push_s   = in_valid && in_ready;

   // Pops happen only from IDLE, or from HOLD on the completing handshake.
   // A command pushed this cycle is not yet visible here (no bypass).
   assign pop_s    = !empty_s &&
                     ((state_q == ST_IDLE) ||
                      ((state_q == ST_HOLD) && out_ready));

   assign head_s   = mem_q[rd_ptr_q[AW-1:0]];

   // Next-state pointers; both wrap naturally modulo 2*DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // FIFO pointer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // FIFO storage: write the accepted command at the tail slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {in_op, in_a, in_b};
      end
   end

   // ------------------------------------------------------------------------
   // Issue FSM with operand register and result register
   // ------------------------------------------------------------------------
   // Sequencer: pop into the operand register, capture the ALU, hold result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         alu_op_q    <= 2'b00;
         alu_a_q     <= 4'b0000;
         alu_b_q     <= 4'b0000;
         out_valid_q <= 1'b0;
         out_op_q    <= 2'b00;
         out_d_q     <= 4'b0000;
         done_cnt_q  <= 8'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               out_valid_q <= 1'b0;
               if (pop_s) begin
                  {alu_op_q, alu_a_q, alu_b_q} <= head_s;
                  state_q                      <= ST_ISSUE;
               end else begin
                  state_q <= ST_IDLE;
               end
            end

            // Operand register has been driving the ALU for a full cycle,
            // so alu_d is settled at this edge.
            ST_ISSUE: begin
               out_d_q     <= alu_d;
               out_op_q    <= alu_op_q;
               out_valid_q <= 1'b1;
               state_q     <= ST_HOLD;
            end

            // Result and valid are frozen until the consumer accepts.
            ST_HOLD: begin
               if (out_ready) begin
                  done_cnt_q  <= done_cnt_q + 8'd1;
                  out_valid_q <= 1'b0;
                  if (pop_s) begin
                     {alu_op_q, alu_a_q, alu_b_q} <= head_s;
                     state_q                      <= ST_ISSUE;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  out_valid_q <= 1'b1;
                  state_q     <= ST_HOLD;
               end
            end

            default: begin
               out_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign alu_op    = alu_op_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign out_valid = out_valid_q;
   assign out_op    = out_op_q;
   assign out_d     = out_d_q;
   assign out_zero  = (out_d_q == 4'b0000);
   assign done_cnt  = done_cnt_q;

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Sequential command front-end that sits directly upstream of the 4-bit combinational ALU (op: 00 AND, 01 shift-left, 10 OR, 11 shift-right). It accepts {op, a, b} commands over a valid/ready handshake and buffers them in a small FIFO. It drives one command at a time onto the ALU's op/a/b inputs, captures the ALU result d one cycle later, and presents it downstream over a second valid/ready handshake. It turns the free-running combinational ALU into a flow-controlled, registered pipeline stage.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- clk  input  1  system clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  command present
- in_ready  output  1  command can be accepted
- in_op  input  2  ALU opcode
- in_a  input  4  operand a
- in_b  input  4  operand b
- alu_op  output  2  to ALU op port
- alu_a  output  4  to ALU a port
- alu_b  output  4  to ALU b port
- alu_d  input  4  from ALU d port (combinational function of alu_op/alu_a/alu_b)
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_op  output  2  opcode that produced out_d
- out_d  output  4  captured ALU result
- out_zero  output  1  out_d == 0
- done_cnt  output  8  count of completed output handshakes

## Operation
- Push: when in_valid && in_ready, {in_op, in_a, in_b} is written to the FIFO tail at the rising edge.
- in_ready = !full && !rst. A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- Operand register {alu_op, alu_a, alu_b} is loaded only on a pop. It holds its value in all other cycles.
- FSM states:
  - IDLE: out_valid=0. If the FIFO is non-empty, pop the head into the operand register and go to ISSUE. Otherwise stay.
  - ISSUE: the operand register drives the ALU. At the edge, capture alu_d→out_d and alu_op→out_op, then go to HOLD.
  - HOLD: out_valid=1; out_d/out_op are stable. On out_ready:
    - increment done_cnt.
    - If the FIFO is non-empty, pop into the operand register and go to ISSUE.
    - Otherwise go to IDLE.
  - Without out_ready: stay in HOLD; outputs are unchanged.
- A command pushed in the same cycle the FIFO is empty is not visible to IDLE until the following cycle. There is no bypass.
- out_zero is computed combinationally from out_d.
- done_cnt is 8 bits unsigned and wraps 255→0.
- FIFO pointers are log2(DEPTH)+1 bits wide, which distinguishes full from empty. Pointers wrap modulo 2·DEPTH.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE; FIFO empty.
  - alu_op/alu_a/alu_b = 0.
  - out_valid=0; out_op=0; out_d=0; done_cnt=0.
  - in_ready=0 while rst is high.
- Latency: push accepted at edge N (IDLE, FIFO empty) → pop at edge N+1 → out_valid=1 after edge N+2.
- Throughput: one result per 2 cycles when out_ready is held high.
- Capacity: DEPTH commands in the FIFO plus one in flight. With out_ready=0, DEPTH+1 commands are accepted before in_ready falls.
- Reset asserted mid-operation: the in-flight command and all queued commands are discarded. No partial handshake completes.
- out_valid must never drop, and out_d/out_op must never change, while HOLD waits for out_ready.

## Test plan
- Single command: push op=00, a=1100, b=1010 with out_ready=1. Required: out_valid rises 2 cycles after the push edge; out_d=1000, out_op=00, out_zero=0; done_cnt=1.
- Shift ops: push op=01 a=0011 b=0001, then op=11 a=1000 b=0101. Required: out_d=0110, then out_d=0000 with out_zero=1.
- Back-to-back stream: push all 4 opcodes with a=0110, b=0011 and out_ready=1. Required results in order: 0010, 0000, 0111, 0000. Each result arrives 2 cycles after the previous one.
- Backpressure: hold out_ready=0 and offer 6 commands (DEPTH=4). Required:
  - exactly 5 are accepted, then in_ready=0;
  - out_d stays stable throughout;
  - releasing out_ready drains all 5 results in push order.
- Reset mid-operation: assert rst while in HOLD with 3 commands queued. Required: out_valid=0, done_cnt=0 and alu_* = 0 immediately; after release, no stale results appear.
- Counter wrap: complete 256 handshakes. Required: done_cnt returns to 0; result order and values match the golden ALU function throughout.
